// File: rtl/cache_mem_arbiter.sv
// Arbitrates the I-cache refill and D-cache refill/write-back ports onto one memory port.
// Define ARB_ROUND_ROBIN_EN for alternating priority; otherwise D always wins over I.
module cache_mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    // I-cache side
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    // D-cache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    // Shared memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D
    } state_t;

    state_t state;
    logic   d_req;
    logic   d_wins;

    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when I should win the next contested arbitration.
    logic prio_i;

    assign d_wins = d_req && (!prio_i || !i_read);
`else
    assign d_wins = d_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            prio_i    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (d_wins) begin
                        // A simultaneous read and write is served as a write-back.
                        state     <= GNT_D;
                        mem_read  <= ~d_write;
                        mem_write <= d_write;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_write ? d_wdata : '0;
                    end else if (i_read) begin
                        state     <= GNT_I;
                        mem_read  <= 1'b1;
                        mem_write <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (mem_ready) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                        prio_i    <= (state == GNT_D);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion is reported in the same cycle memory answers; gated so reset aborts silently.
    assign i_ready = rst_n && (state == GNT_I) && mem_ready;
    assign d_ready = rst_n && (state == GNT_D) && mem_ready;
    assign i_rdata = (state == GNT_I) ? mem_rdata : '0;
    assign d_rdata = (state == GNT_D) ? mem_rdata : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed requests, a latency-programmable memory
// model, auto-deasserting requesters and a monitor that checks every completion in order.
module tb_cache_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic          i_ready, d_ready, mem_read, mem_write, mem_ready;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    typedef struct {
        bit            is_d;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   lat = 3;
    bit   idle_noise = 1'b0;
    int   i_rearm = 0;
    int   d_rearm = 0;
    int   mem_cnt = 0;
    bit   smp_i, smp_d;
    logic prev_cmd = 1'b0, prev_rdy = 1'b0, prev_rd = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wdata = '0;

    function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        if (a == 28'h10) r = {16{8'hA5}};
        else r = {4{4'h5, a}};
        return r;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input bit is_d, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd);
        exp_t e;
        e.is_d  = is_d;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = wd;
        exp_q.push_back(e);
    endtask

    // Memory model: answers after lat cycles of an active command.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_read || mem_write) begin
                mem_cnt++;
                mem_ready = (mem_cnt == lat);
                mem_rdata = mem_ready ? rd_of(mem_addr) : '0;
            end else begin
                mem_cnt   = 0;
                mem_ready = idle_noise;
                mem_rdata = '0;
            end
        end
    end

    // Requesters drop on the edge after their ready unless asked to re-request.
    initial begin
        forever begin
            @(negedge clk);
            smp_i = i_ready;
            smp_d = d_ready;
            @(posedge clk);
            #1;
            if (smp_i) begin
                if (i_rearm > 0) i_rearm--;
                else i_read = 1'b0;
            end
            if (smp_d) begin
                if (d_rearm > 0) d_rearm--;
                else begin
                    d_read  = 1'b0;
                    d_write = 1'b0;
                end
            end
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on every completion.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_read | mem_write) chk1("mem_cmd_excl", mem_read & mem_write, 1'b0);
                if (prev_rdy) chk1("idle_gap", mem_read | mem_write, 1'b0);
                if (prev_cmd && !prev_rdy && (mem_read | mem_write)) begin
                    chka("hold_addr", mem_addr, prev_addr);
                    chkd("hold_wdata", mem_wdata, prev_wdata);
                    chk1("hold_read", mem_read, prev_rd);
                end
                if (i_ready | d_ready) begin
                    chk1("ready_excl", i_ready & d_ready, 1'b0);
                    if (exp_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_ready: i_ready=%0b d_ready=%0b, required none",
                                 i_ready, d_ready);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk1("grant_port", d_ready, mon_e.is_d);
                        chk1("cmd_write", mem_write, mon_e.wr);
                        chk1("cmd_read", mem_read, !mon_e.wr);
                        chka("cmd_addr", mem_addr, mon_e.addr);
                        if (mon_e.wr) chkd("cmd_wdata", mem_wdata, mon_e.wdata);
                        if (mon_e.is_d) begin
                            if (!mon_e.wr) chkd("d_rdata", d_rdata, rd_of(mon_e.addr));
                            chkd("i_rdata_idle", i_rdata, '0);
                        end else begin
                            chkd("i_rdata", i_rdata, rd_of(mon_e.addr));
                            chkd("d_rdata_idle", d_rdata, '0);
                        end
                    end
                end
            end
            prev_cmd   = mem_read | mem_write;
            prev_rdy   = i_ready | d_ready;
            prev_rd    = mem_read;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: %0d transactions outstanding, required 0", name,
                     exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        i_rearm = 0;
        d_rearm = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chka("rst_mem_addr", mem_addr, '0);
        chkd("rst_mem_wdata", mem_wdata, '0);
        chk1("rst_i_ready", i_ready, 1'b0);
        chk1("rst_d_ready", d_ready, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Simultaneous requests after reset: D first, then I after an idle cycle.
        lat = 2;
        i_addr = 28'h100; d_addr = 28'h200; d_wdata = '0;
        i_read = 1'b1; d_read = 1'b1;
        push(1'b1, 1'b0, 28'h200, '0);
        push(1'b0, 1'b0, 28'h100, '0);
        @(negedge clk);
        @(negedge clk);
        chka("both_first_addr", mem_addr, 28'h200);
        wait_done("both");

        // Single I refill, memory answers in the third grant cycle.
        lat = 3;
        i_addr = 28'h10; i_read = 1'b1;
        push(1'b0, 1'b0, 28'h10, '0);
        @(negedge clk);
        chk1("i_pre_grant_read", mem_read, 1'b0);
        @(negedge clk);
        chk1("i_grant_read", mem_read, 1'b1);
        chka("i_grant_addr", mem_addr, 28'h10);
        @(negedge clk);
        chk1("i_ready_early", i_ready, 1'b0);
        @(negedge clk);
        chk1("i_ready_c3", i_ready, 1'b1);
        chkd("i_rdata_a5", i_rdata, {16{8'hA5}});
        wait_done("i_refill");

        // Write-back, then read+write served as write; spurious idle mem_ready must be ignored.
        idle_noise = 1'b1;
        lat = 1;
        d_addr = 28'h20; d_wdata = 128'h1234; d_write = 1'b1;
        push(1'b1, 1'b1, 28'h20, 128'h1234);
        wait_done("d_write");
        d_addr = 28'h24; d_wdata = 128'h5678; d_read = 1'b1; d_write = 1'b1;
        push(1'b1, 1'b1, 28'h24, 128'h5678);
        wait_done("d_rw");
        idle_noise = 1'b0;

        // Reset in the middle of an I grant: no ready, then a clean D refill.
        lat = 6;
        i_addr = 28'h30; i_read = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0; i_read = 1'b0;
        @(negedge clk);
        chk1("abort_no_ready_pre", i_ready, 1'b0);
        @(negedge clk);
        chk1("abort_mem_read", mem_read, 1'b0);
        chk1("abort_mem_write", mem_write, 1'b0);
        chka("abort_mem_addr", mem_addr, '0);
        chkd("abort_mem_wdata", mem_wdata, '0);
        chk1("abort_i_ready", i_ready, 1'b0);
        chk1("abort_d_ready", d_ready, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        lat = 2;
        d_addr = 28'h40; d_read = 1'b1;
        push(1'b1, 1'b0, 28'h40, '0);
        @(negedge clk);
        @(negedge clk);
        chk1("post_rst_grant", mem_read, 1'b1);
        chka("post_rst_addr", mem_addr, 28'h40);
        wait_done("post_rst");

        // Both requesters held for two transactions each.
        do_reset();
        i_addr = 28'h50; d_addr = 28'h60;
        i_rearm = 1; d_rearm = 1;
        i_read = 1'b1; d_read = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        push(1'b1, 1'b0, 28'h60, '0);
        push(1'b0, 1'b0, 28'h50, '0);
        push(1'b1, 1'b0, 28'h60, '0);
        push(1'b0, 1'b0, 28'h50, '0);
`else
        push(1'b1, 1'b0, 28'h60, '0);
        push(1'b1, 1'b0, 28'h60, '0);
        push(1'b0, 1'b0, 28'h50, '0);
        push(1'b0, 1'b0, 28'h50, '0);
`endif
        wait_done("held");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, meaning the cache-line address width.
REQ-002 SHALL have parameter DATA_W, default 128, meaning the cache-line data width.
REQ-003 SHALL have port clk, input, 1 bit: the clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port i_read, input, 1 bit: I-cache line-refill request, held until i_ready.
REQ-006 SHALL have port i_addr, input, ADDR_W bits: I-cache line address.
REQ-007 SHALL have port i_rdata, output, DATA_W bits: I-cache refill data.
REQ-008 SHALL have port i_ready, output, 1 bit: one-cycle I-cache completion pulse.
REQ-009 SHALL have port d_read, input, 1 bit: D-cache refill request, held until d_ready.
REQ-010 SHALL have port d_write, input, 1 bit: D-cache write-back request, held until d_ready.
REQ-011 SHALL have port d_addr, input, ADDR_W bits: D-cache line address.
REQ-012 SHALL have port d_wdata, input, DATA_W bits: D-cache write-back data.
REQ-013 SHALL have port d_rdata, output, DATA_W bits: D-cache refill data.
REQ-014 SHALL have port d_ready, output, 1 bit: one-cycle D-cache completion pulse.
REQ-015 SHALL have ports mem_read and mem_write, outputs, 1 bit each: the shared memory command.
REQ-016 SHALL have port mem_addr, output, ADDR_W bits, and port mem_wdata, output, DATA_W bits.
REQ-017 SHALL have port mem_rdata, input, DATA_W bits, and port mem_ready, input, 1 bit: memory completion.

Function
REQ-018 SHALL implement a three-state FSM with states IDLE, GNT_I and GNT_D.
REQ-019 In IDLE, SHALL move to GNT_D if (d_read|d_write) and D has priority, else to GNT_I if i_read, else stay in IDLE.
REQ-020 SHALL register mem_addr, mem_wdata and the command on the grant edge, so a memory command starts 1 cycle after the request is sampled.
REQ-021 SHALL hold the command constant during GNT_x until mem_ready=1.
REQ-022 In GNT_x with mem_ready=1, SHALL pulse the matching x_ready for exactly that cycle, drive x_rdata=mem_rdata combinationally, drop the command, and return to IDLE.
REQ-023 SHALL keep at least one IDLE cycle between consecutive grants; requesters deassert on the edge after x_ready.
REQ-024 SHALL treat d_read=d_write=1 as a write (mem_write=1, mem_read=0).
REQ-025 SHALL never assert mem_read and mem_write together, and never assert i_ready and d_ready together.
REQ-026 SHALL ignore mem_ready in IDLE and ignore request changes during GNT_x.
REQ-027 SHALL drive the non-granted x_rdata as 0 and the non-granted x_ready as 0.

Reset
REQ-028 While rst_n=0, SHALL set state=IDLE, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, i_ready=d_ready=0, and clear the priority flag to favour D.
REQ-029 SHALL abandon an in-flight transaction on reset with no x_ready pulse, and re-arbitrate normally from the first cycle after rst_n=1.

Configuration
REQ-030 With ARB_ROUND_ROBIN_EN defined, SHALL toggle the priority after each completed grant, with last-granted-D giving I priority next and vice versa.
REQ-031 Without ARB_ROUND_ROBIN_EN, SHALL give D fixed priority over I and keep no priority flag.

Verification
REQ-032 Apply i_read=1, i_addr=0x0000010, mem_ready after 3 cycles in grant, mem_rdata=0xA5..A5 -> mem_read=1 from cycle 1 with mem_addr=0x10, i_ready pulses once, i_rdata=0xA5..A5.
REQ-033 Apply i_read and d_read in the same cycle with the default build -> GNT_D first; GNT_I is granted after one IDLE cycle.
REQ-034 Hold i_read and d_read continuously with ARB_ROUND_ROBIN_EN -> grants alternate D, I, D, I over 4 transactions.
REQ-035 Apply d_write=1, d_wdata=0x1234, d_addr=0x20 -> mem_write=1, mem_read=0, mem_wdata=0x1234, d_ready pulses when mem_ready=1.
REQ-036 Assert rst_n=0 during GNT_I before mem_ready -> outputs reach their reset values next cycle, no i_ready, and the first request after release is granted normally.
